uart_rx_fsm: RTL and testbench



---
 rtl/uart_rx_fsm_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 41 ++++
 rtl/uart_rx_fsm.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fsm_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_pkg
// Shared definitions for the UART receive path: default frame geometry and
// the 3-bit receive state encoding used by uart_rx_fsm.
//
// Build-time macros:
//   UART_RX_PARITY_EN - enables the even-parity bit (used in uart_rx_fsm).
// -----------------------------------------------------------------------------
package uart_rx_fsm_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam int DEFAULT_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START_BIT  = 3'd1,
      ST_DATA_BIT   = 3'd2,
      ST_PARITY_BIT = 3'd3,
      ST_STOP_BIT   = 3'd4,
      ST_BREAK_WAIT = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// 1 so an idle-high line (UART RX, CTS) reads as idle straight out of reset.
//
// Ports:
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset
//   async_in - asynchronous input
//   sync_out - input synchronized to clk (two cycles of latency)
// -----------------------------------------------------------------------------
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// UART receiver running on an oversampled clock (OVERSAMPLE ticks per bit).
// Recovers start bit, DATA_WIDTH data bits LSB-first, an optional even-parity
// bit and one stop bit, then presents the word with a one-cycle valid pulse
// and qualifying error flags. Errored frames are still delivered.
//
// Build-time macro:
//   UART_RX_PARITY_EN - when defined, a parity bit follows the data bits and
//                       parity_err reports even-parity mismatches; otherwise
//                       there is no parity bit and parity_err is tied to 0.
//
// Ports:
//   rx_clk     - receive clock, OVERSAMPLE x baud
//   resetn     - asynchronous active-low reset
//   rx_in      - serial line, asynchronous, idle high
//   rx_data    - last received word, held until the next frame completes
//   rx_valid   - one-cycle pulse when a frame completes
//   parity_err - parity mismatch, qualified by rx_valid
//   frame_err  - stop bit sampled low, qualified by rx_valid
//   rx_busy    - high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_fsm
   import uart_rx_fsm_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic                  rx_clk,
   input  logic                  resetn,
   input  logic                  rx_in,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  rx_busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

   localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   logic rx_s;

   rx_state_e             state_q,      state_d;
   logic [TICK_W-1:0]     tick_q,       tick_d;
   logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,      shift_d;
   logic [DATA_WIDTH-1:0] data_q,       data_d;
   logic                  valid_q,      valid_d;
   logic                  frame_err_q,  frame_err_d;
`ifdef UART_RX_PARITY_EN
   // par_calc holds the parity verdict between the parity and stop bits;
   // parity_err itself is only published alongside rx_valid.
   logic                  par_calc_q,   par_calc_d;
   logic                  parity_err_q, parity_err_d;
`endif

   uart_rx_sync u_sync (
      .clk      (rx_clk),
      .rst_n    (resetn),
      .async_in (rx_in),
      .sync_out (rx_s)
   );

   // Next-state and datapath logic. The tick counter free-runs within a bit
   // and is cleared at every sampling point; the start bit is sampled at
   // mid-bit so that every later sample, taken a full bit later, lands on a
   // bit centre.
   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q + 1'b1;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_calc_d   = par_calc_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            tick_d = '0;
            if (!rx_s) begin
               state_d = ST_START_BIT;
            end
         end

         ST_START_BIT: begin
            if (tick_q == TICK_MID) begin
               tick_d = '0;
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DATA_BIT;
                  bit_cnt_d = '0;
               end
            end
         end

         ST_DATA_BIT: begin
            if (tick_q == TICK_END) begin
               tick_d    = '0;
               shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY_BIT;
`else
                  state_d = ST_STOP_BIT;
`endif
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY_BIT: begin
            if (tick_q == TICK_END) begin
               tick_d     = '0;
               par_calc_d = (^shift_q) ^ rx_s;
               state_d    = ST_STOP_BIT;
            end
         end
`endif

         ST_STOP_BIT: begin
            if (tick_q == TICK_END) begin
               tick_d      = '0;
               data_d      = shift_q;
               valid_d     = 1'b1;
               frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
               parity_err_d = par_calc_q;
`endif
               // A low stop bit may be the start of a break; wait for the
               // line to return high so it is not mistaken for a new frame.
               state_d = rx_s ? ST_IDLE : ST_BREAK_WAIT;
            end
         end

         ST_BREAK_WAIT: begin
            tick_d = '0;
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            tick_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge rx_clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         tick_q       <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_calc_q   <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         par_calc_q   <= par_calc_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Directed self-checking bench for uart_rx_fsm with OVERSAMPLE = 16 and
// DATA_WIDTH = 8. Frame length and parity expectations follow the
// UART_RX_PARITY_EN build macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fsm;

   localparam int DW = 8;
   localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME_BITS = 1 + DW + P + 1;
   localparam int LATENCY    = 2 + OS / 2 + (DW + P + 1) * OS;
   localparam int FRAME_CYC  = FRAME_BITS * OS;

   logic          rx_clk = 1'b0;
   logic          resetn = 1'b0;
   logic          rx_in  = 1'b1;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          parity_err;
   logic          frame_err;
   logic          rx_busy;

   int compare_cnt = 0;
   int fail_cnt    = 0;

   int            cycle_cnt         = 0;
   int            pulse_cnt         = 0;
   int            last_pulse_cycle  = 0;
   int            last_gap          = 0;
   int            frame_start_cycle = 0;
   int            pulses_before     = 0;
   logic [DW-1:0] last_data         = '0;
   logic          last_perr         = 1'b0;
   logic          last_ferr         = 1'b0;
   logic          busy_after        = 1'b1;
   logic          valid_after       = 1'b1;
   logic          prev_valid        = 1'b0;

   uart_rx_fsm #(
      .DATA_WIDTH (DW),
      .OVERSAMPLE (OS)
   ) dut (
      .rx_clk     (rx_clk),
      .resetn     (resetn),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .rx_busy    (rx_busy)
   );

   always #5 rx_clk = ~rx_clk;

   always @(posedge rx_clk) cycle_cnt <= cycle_cnt + 1;

   // Pulse monitor, sampled on the falling edge away from the active edge.
   always @(negedge rx_clk) begin
      if (prev_valid) begin
         busy_after  = rx_busy;
         valid_after = rx_valid;
      end
      if (rx_valid) begin
         pulse_cnt        = pulse_cnt + 1;
         last_gap         = cycle_cnt - last_pulse_cycle;
         last_pulse_cycle = cycle_cnt;
         last_data        = rx_data;
         last_perr        = parity_err;
         last_ferr        = frame_err;
      end
      prev_valid = rx_valid;
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      compare_cnt++;
      assert (observed === expected) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge rx_clk);
      #1;
   endtask

   // Drives one complete frame; each bit lasts exactly OS clock cycles so
   // consecutive calls produce back-to-back frames with no idle gap.
   task automatic apply_frame(input logic [DW-1:0] data, input logic pbit,
                              input logic stop);
      logic [10:0] frame;
      frame = (P == 1) ? {stop, pbit, data, 1'b0} : {1'b0, stop, data, 1'b0};
      frame_start_cycle = cycle_cnt;
      for (int i = 0; i < FRAME_BITS; i++) begin
         rx_in = frame[i];
         wait_cycles(OS);
      end
   endtask

   initial begin
      $display("[TB] uart_rx_fsm bench, parity bit count %0d", P);

      // Reset state
      wait_cycles(3);
      check_output("reset rx_data",    rx_data,    0);
      check_output("reset rx_valid",   rx_valid,   0);
      check_output("reset parity_err", parity_err, 0);
      check_output("reset frame_err",  frame_err,  0);
      check_output("reset rx_busy",    rx_busy,    0);
      resetn = 1'b1;
      wait_cycles(4);

      // Nominal 0xA5 (four ones, even parity bit 0)
      pulses_before = pulse_cnt;
      apply_frame(8'hA5, 1'b0, 1'b1);
      wait_cycles(4);
      check_output("nominal pulses",     pulse_cnt - pulses_before, 1);
      check_output("nominal data",       last_data, 8'hA5);
      check_output("nominal parity_err", last_perr, 0);
      check_output("nominal frame_err",  last_ferr, 0);
      check_output("nominal single cycle", valid_after, 0);
      check_output("nominal busy after", busy_after, 0);
      // The first edge that samples the low line is frame_start_cycle + 1.
      check_output("nominal latency", last_pulse_cycle - frame_start_cycle, 1 + LATENCY);

      // Glitch: 5 cycles low is shorter than half a bit
      pulses_before = pulse_cnt;
      rx_in = 1'b0;
      wait_cycles(5);
      rx_in = 1'b1;
      check_output("glitch busy during", rx_busy, 1);
      wait_cycles(20);
      check_output("glitch busy after", rx_busy, 0);
      check_output("glitch pulses", pulse_cnt - pulses_before, 0);

      // Parity error: 0x3C has even ones, so a parity bit of 1 is wrong
      pulses_before = pulse_cnt;
      apply_frame(8'h3C, 1'b1, 1'b1);
      wait_cycles(4);
      check_output("parity pulses",     pulse_cnt - pulses_before, 1);
      check_output("parity data",       last_data, 8'h3C);
      check_output("parity parity_err", last_perr, (P == 1) ? 1 : 0);
      check_output("parity frame_err",  last_ferr, 0);

      // Framing error followed by a 40-bit break
      pulses_before = pulse_cnt;
      apply_frame(8'h00, 1'b0, 1'b0);
      wait_cycles(40 * OS);
      check_output("break pulses",     pulse_cnt - pulses_before, 1);
      check_output("break data",       last_data, 8'h00);
      check_output("break frame_err",  last_ferr, 1);
      check_output("break parity_err", last_perr, 0);
      check_output("break busy held",  rx_busy, 1);
      rx_in = 1'b1;
      wait_cycles(8);
      check_output("break busy released", rx_busy, 0);
      check_output("break no extra pulse", pulse_cnt - pulses_before, 1);
      apply_frame(8'h5A, 1'b0, 1'b1);
      wait_cycles(4);
      check_output("post-break pulses",    pulse_cnt - pulses_before, 2);
      check_output("post-break data",      last_data, 8'h5A);
      check_output("post-break frame_err", last_ferr, 0);
      check_output("post-break parity_err", last_perr, 0);

      // Reset in the middle of bit 3 of 0xFF
      pulses_before = pulse_cnt;
      rx_in = 1'b0;
      wait_cycles(OS);
      rx_in = 1'b1;
      wait_cycles(3 * OS + OS / 2);
      check_output("midframe busy", rx_busy, 1);
      resetn = 1'b0;
      #1;
      check_output("midreset rx_data",    rx_data,    0);
      check_output("midreset rx_valid",   rx_valid,   0);
      check_output("midreset rx_busy",    rx_busy,    0);
      check_output("midreset parity_err", parity_err, 0);
      check_output("midreset frame_err",  frame_err,  0);
      wait_cycles(4);
      resetn = 1'b1;
      wait_cycles(4 * OS);
      check_output("midreset no pulse", pulse_cnt - pulses_before, 0);
      apply_frame(8'h81, 1'b0, 1'b1);
      wait_cycles(4);
      check_output("after reset pulses", pulse_cnt - pulses_before, 1);
      check_output("after reset data",   last_data, 8'h81);
      check_output("after reset frame_err", last_ferr, 0);

      // Back-to-back frames with no idle gap
      pulses_before = pulse_cnt;
      apply_frame(8'h01, 1'b1, 1'b1);
      check_output("b2b data 0x01", last_data, 8'h01);
      apply_frame(8'h80, 1'b1, 1'b1);
      check_output("b2b data 0x80", last_data, 8'h80);
      check_output("b2b gap 1", last_gap, FRAME_CYC);
      apply_frame(8'hFF, 1'b0, 1'b1);
      check_output("b2b data 0xFF", last_data, 8'hFF);
      check_output("b2b gap 2", last_gap, FRAME_CYC);
      check_output("b2b parity_err", last_perr, 0);
      wait_cycles(4);
      check_output("b2b pulses", pulse_cnt - pulses_before, 3);

      // Line held low across reset release
      resetn = 1'b0;
      rx_in  = 1'b0;
      wait_cycles(4);
      pulses_before = pulse_cnt;
      resetn = 1'b1;
      wait_cycles(FRAME_CYC + 2 * OS);
      check_output("low-reset pulses",    pulse_cnt - pulses_before, 1);
      check_output("low-reset data",      last_data, 8'h00);
      check_output("low-reset frame_err", last_ferr, 1);
      check_output("low-reset busy",      rx_busy, 1);
      rx_in = 1'b1;
      wait_cycles(8);
      check_output("low-reset busy released", rx_busy, 0);
      check_output("low-reset single pulse", pulse_cnt - pulses_before, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
      $finish;
   end

endmodule
